multi_channel_pi: RTL and testbench

MULTI_CHANNEL_PI -- requirements
Module: multi_channel_pi

---
 rtl/multi_channel_pi.sv | 180 ++++++++++++++++++
 tb/tb_multi_channel_pi.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_pi.sv
// Time-multiplexed PI controller: N_CH channels share one multiplier pair.
// Each run walks ERR -> INT -> MUL -> SUM -> OUT once per channel, then pulses done.
module multi_channel_pi #(
    parameter int N_CH = 2,
    parameter int IW   = 12,
    parameter int OW   = 16,
    parameter int KW   = 16,
    parameter int FRAC = 9,
    parameter int AW   = 20
) (
    input  logic                 iClk,
    input  logic                 iRst_n,
    input  logic                 iCal_en,
    input  logic [N_CH*IW-1:0]   iTarget,
    input  logic [N_CH*IW-1:0]   iFeedback,
    input  logic [N_CH*KW-1:0]   iKp,
    input  logic [N_CH*KW-1:0]   iKi,
    input  logic [OW-2:0]        iLimit,
    input  logic                 iInt_clr,
    output logic [N_CH*OW-1:0]   oCal,
    output logic [N_CH-1:0]      oSat,
    output logic                 oBusy,
    output logic                 oCal_done
);
    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int PW = KW + IW;
    localparam int QW = KW + AW;
    localparam int SW = ((PW > QW) ? PW : QW) + 1;
    localparam logic signed [IW:0]   ERR_MAX = (IW+1)'((1 << (IW-1)) - 1);
    localparam logic signed [IW-1:0] ERR_POS = IW'((1 << (IW-1)) - 1);
    localparam logic signed [AW:0]   INT_MAX = (AW+1)'((1 << (AW-1)) - 1);
    localparam logic signed [AW-1:0] INT_POS = AW'((1 << (AW-1)) - 1);

    typedef enum logic [2:0] {IDLE, ERR, INT, MUL, SUM, OUT, DONE} state_t;

    state_t state, next_state;
    logic [CW-1:0]        ch;
    logic                 cal_en_q, armed;
    logic [N_CH*IW-1:0]   tgt_q, fb_q;
    logic [N_CH*KW-1:0]   kp_q, ki_q;
    logic [OW-2:0]        limit_q;
    logic signed [AW-1:0] integ [N_CH];
    logic signed [IW-1:0] err_q;
    logic                 hold_q;
    logic signed [PW-1:0] p_q;
    logic signed [QW-1:0] i_q;
    logic signed [SW-1:0] s_q;

    logic start, clear, last_ch;
    logic signed [IW-1:0] tgt_sel, fb_sel, err_c;
    logic signed [KW-1:0] kp_sel, ki_sel;
    logic signed [IW:0]   diff;
    logic                 hold_c;
    logic signed [AW:0]   isum;
    logic signed [AW-1:0] integ_c;
    logic signed [PW-1:0] prod_p;
    logic signed [QW-1:0] prod_i;
    logic signed [SW-1:0] sum_c, lim_s, neg_lim_s;
    logic [OW-1:0]        lim_o, out_c;
    logic                 sat_c;

    // armed stays low after reset until iCal_en has been seen low once
    assign start   = iCal_en & ~cal_en_q & armed & (state == IDLE);
    assign clear   = iInt_clr & (state == IDLE);
    assign last_ch = (ch == CW'(N_CH - 1));

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) state <= IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        oBusy      = (state != IDLE);
        oCal_done  = (state == DONE);
        case (state)
            IDLE:    if (start) next_state = ERR;
            ERR:     next_state = INT;
            INT:     next_state = MUL;
            MUL:     next_state = SUM;
            SUM:     next_state = OUT;
            OUT:     next_state = last_ch ? DONE : ERR;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        tgt_sel = tgt_q[ch*IW +: IW];
        fb_sel  = fb_q[ch*IW +: IW];
        kp_sel  = kp_q[ch*KW +: KW];
        ki_sel  = ki_q[ch*KW +: KW];
        diff    = {tgt_sel[IW-1], tgt_sel} - {fb_sel[IW-1], fb_sel};
        if (diff > ERR_MAX)       err_c = ERR_POS;
        else if (diff < -ERR_MAX) err_c = -ERR_POS;
        else                      err_c = diff[IW-1:0];
        hold_c = oSat[ch] & (err_c[IW-1] == oCal[ch*OW + OW - 1]);

        isum = (AW+1)'(integ[ch]) + (AW+1)'(err_q);
        if (isum > INT_MAX)       integ_c = INT_POS;
        else if (isum < -INT_MAX) integ_c = -INT_POS;
        else                      integ_c = isum[AW-1:0];

        prod_p = PW'(kp_sel) * PW'(err_q);
        prod_i = QW'(ki_sel) * QW'(integ[ch]);
        sum_c  = SW'(p_q) + SW'(i_q);

        // limit is unsigned, so it is zero-extended before the signed compare
        lim_s     = SW'($signed({1'b0, limit_q}));
        neg_lim_s = -lim_s;
        lim_o     = {1'b0, limit_q};
        if (s_q > lim_s) begin
            out_c = lim_o;
            sat_c = 1'b1;
        end else if (s_q < neg_lim_s) begin
            out_c = -lim_o;
            sat_c = 1'b1;
        end else begin
            out_c = s_q[OW-1:0];
            sat_c = 1'b0;
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            ch       <= '0;
            cal_en_q <= 1'b0;
            armed    <= 1'b0;
            tgt_q    <= '0;
            fb_q     <= '0;
            kp_q     <= '0;
            ki_q     <= '0;
            limit_q  <= '0;
            err_q    <= '0;
            hold_q   <= 1'b0;
            p_q      <= '0;
            i_q      <= '0;
            s_q      <= '0;
            oCal     <= '0;
            oSat     <= '0;
            for (int k = 0; k < N_CH; k++) integ[k] <= '0;
        end else begin
            cal_en_q <= iCal_en;
            if (!iCal_en) armed <= 1'b1;
            // clear and a same-cycle start coexist: the run sees zeroed state
            if (clear) begin
                oSat <= '0;
                for (int k = 0; k < N_CH; k++) integ[k] <= '0;
            end
            case (state)
                IDLE: begin
                    ch <= '0;
                    if (start) begin
                        tgt_q   <= iTarget;
                        fb_q    <= iFeedback;
                        kp_q    <= iKp;
                        ki_q    <= iKi;
                        limit_q <= iLimit;
                    end
                end
                ERR: begin
                    err_q  <= err_c;
                    hold_q <= hold_c;
                end
                INT: if (!hold_q) integ[ch] <= integ_c;
                MUL: begin
                    p_q <= prod_p >>> FRAC;
                    i_q <= prod_i >>> FRAC;
                end
                SUM: s_q <= sum_c;
                OUT: begin
                    oCal[ch*OW +: OW] <= out_c;
                    oSat[ch]          <= sat_c;
                    if (!last_ch) ch <= ch + CW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multi_channel_pi.sv
// Directed bench for multi_channel_pi (N_CH=2 defaults); expected values worked out by hand.
module tb_multi_channel_pi;
    logic        iClk = 1'b0;
    logic        iRst_n;
    logic        iCal_en;
    logic [23:0] iTarget, iFeedback;
    logic [31:0] iKp, iKi;
    logic [14:0] iLimit;
    logic        iInt_clr;
    logic [31:0] oCal;
    logic [1:0]  oSat;
    logic        oBusy, oCal_done;

    int checks = 0;
    int errors = 0;
    int done_total = 0;
    int runs = 0;
    int done_before;

    multi_channel_pi dut (
        .iClk(iClk), .iRst_n(iRst_n), .iCal_en(iCal_en),
        .iTarget(iTarget), .iFeedback(iFeedback), .iKp(iKp), .iKi(iKi),
        .iLimit(iLimit), .iInt_clr(iInt_clr),
        .oCal(oCal), .oSat(oSat), .oBusy(oBusy), .oCal_done(oCal_done)
    );

    always #5 iClk = ~iClk;

    always @(negedge iClk) if (oCal_done === 1'b1) done_total++;

    initial begin
        #400000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    function automatic logic signed [31:0] cal(input int k);
        logic signed [15:0] v;
        v = oCal[k*16 +: 16];
        return 32'(v);
    endfunction

    task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                               input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int t0, input int f0, input int kp0, input int ki0,
                                 input int t1, input int f1, input int kp1, input int ki1,
                                 input int lim);
        @(negedge iClk);
        iTarget   = {12'(t1), 12'(t0)};
        iFeedback = {12'(f1), 12'(f0)};
        iKp       = {16'(kp1), 16'(kp0)};
        iKi       = {16'(ki1), 16'(ki0)};
        iLimit    = 15'(lim);
    endtask

    task automatic clearInt();
        @(negedge iClk) iInt_clr = 1'b1;
        @(negedge iClk) iInt_clr = 1'b0;
    endtask

    // mode 0 plain, 1 inputs scrambled mid-run, 2 edge+clear while busy, 3 clear with start
    task automatic runCalc(input int mode);
        int          done_cnt, done_at, busy_cnt;
        logic [23:0] st, sf;
        logic [31:0] skp, ski;
        logic [14:0] sl;
        done_cnt = 0;
        done_at  = -1;
        busy_cnt = 0;
        st = iTarget; sf = iFeedback; skp = iKp; ski = iKi; sl = iLimit;
        runs++;
        @(negedge iClk);
        iCal_en = 1'b1;
        if (mode == 3) iInt_clr = 1'b1;
        @(posedge iClk); #1;
        iInt_clr = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            if (oBusy === 1'b1) busy_cnt++;
            if (oCal_done === 1'b1) begin
                done_cnt++;
                done_at = k;
            end
            if (mode == 1 && k == 1) begin
                iTarget = '0; iFeedback = 24'h7FF7FF; iKp = '1; iKi = '1; iLimit = 15'd1;
            end
            if (mode == 2 && k == 3) iCal_en = 1'b0;
            if (mode == 2 && k == 4) iInt_clr = 1'b1;
            if (mode == 2 && k == 5) begin
                iCal_en  = 1'b1;
                iInt_clr = 1'b0;
            end
            @(posedge iClk); #1;
        end
        iTarget = st; iFeedback = sf; iKp = skp; iKi = ski; iLimit = sl;
        checkOutput("busy_cycles", busy_cnt, 11);
        checkOutput("done_count", done_cnt, 1);
        checkOutput("done_cycle", done_at, 11);
        @(negedge iClk) iCal_en = 1'b0;
    endtask

    initial begin
        iRst_n   = 1'b0;
        iCal_en  = 1'b1;
        iInt_clr = 1'b0;
        iTarget  = '0; iFeedback = '0; iKp = '0; iKi = '0; iLimit = '0;
        #1;
        checkOutput("rst_cal", 32'(oCal), 0);
        checkOutput("rst_sat", 32'(oSat), 0);
        checkOutput("rst_busy", 32'(oBusy), 0);
        checkOutput("rst_done", 32'(oCal_done), 0);
        repeat (3) @(posedge iClk);
        @(negedge iClk) iRst_n = 1'b1;
        repeat (5) @(posedge iClk);
        #1;
        checkOutput("no_start_held_high", 32'(oBusy), 0);
        checkOutput("no_done_held_high", done_total, 0);
        @(negedge iClk) iCal_en = 1'b0;

        // ch0 proportional only, ch1 integral only with err=10
        applyStimulus(100, 0, 512, 0, 10, 0, 0, 512, 32767);
        runCalc(0);
        checkOutput("p_only_ch0", cal(0), 100);
        checkOutput("p_only_sat", 32'(oSat), 0);
        checkOutput("integ_run1", cal(1), 10);
        runCalc(2);
        checkOutput("integ_run2", cal(1), 20);
        checkOutput("ch0_run2", cal(0), 100);
        runCalc(1);
        checkOutput("integ_run3", cal(1), 30);
        checkOutput("ch0_run3", cal(0), 100);
        clearInt();
        checkOutput("clr_keeps_cal", cal(1), 30);
        runCalc(0);
        checkOutput("integ_after_clr", cal(1), 10);

        // error clamping at both extremes
        applyStimulus(2047, -2048, 512, 0, 10, 0, 0, 512, 32767);
        runCalc(0);
        checkOutput("err_clamp_pos", cal(0), 2047);
        checkOutput("err_clamp_pos_sat", 32'(oSat[0]), 0);
        applyStimulus(-2048, 2047, 512, 0, 10, 0, 0, 512, 32767);
        runCalc(0);
        checkOutput("err_clamp_neg", cal(0), -2047);

        // saturation and anti-windup hold
        clearInt();
        applyStimulus(100, 0, 16384, 512, 10, 0, 0, 512, 1000);
        runCalc(0);
        checkOutput("sat_pos_cal", cal(0), 1000);
        checkOutput("sat_pos_flags", 32'(oSat), 1);
        checkOutput("sat_ch1", cal(1), 10);
        runCalc(0);
        checkOutput("sat_pos_cal2", cal(0), 1000);
        applyStimulus(0, 0, 0, 512, 10, 0, 0, 512, 1000);
        runCalc(0);
        checkOutput("held_integ", cal(0), 100);
        checkOutput("held_sat", 32'(oSat[0]), 0);
        applyStimulus(0, 100, 16384, 512, 10, 0, 0, 512, 1000);
        runCalc(0);
        checkOutput("sat_neg_cal", cal(0), -1000);
        checkOutput("sat_neg_flag", 32'(oSat[0]), 1);
        clearInt();
        checkOutput("clr_sat", 32'(oSat), 0);
        checkOutput("clr_keeps_neg", cal(0), -1000);
        applyStimulus(0, 0, 0, 512, 10, 0, 0, 512, 1000);
        runCalc(0);
        checkOutput("integ_zero", cal(0), 0);
        checkOutput("ch1_after_clr", cal(1), 10);

        // zero limit forces zero output and flags saturation
        applyStimulus(100, 0, 512, 0, 10, 0, 0, 512, 0);
        runCalc(0);
        checkOutput("lim0_ch0", cal(0), 0);
        checkOutput("lim0_ch1", cal(1), 0);
        checkOutput("lim0_sat", 32'(oSat), 3);

        // clear together with start: ch1 would otherwise hold at 20
        applyStimulus(100, 0, 512, 0, 10, 0, 0, 512, 32767);
        runCalc(3);
        checkOutput("clr_start_ch1", cal(1), 10);
        checkOutput("clr_start_ch0", cal(0), 100);
        checkOutput("clr_start_sat", 32'(oSat), 0);

        // reset in cycle 4 of a run
        done_before = done_total;
        @(negedge iClk) iCal_en = 1'b1;
        @(posedge iClk);
        repeat (3) @(posedge iClk);
        #1 iRst_n = 1'b0;
        #1;
        checkOutput("midrun_rst_cal", 32'(oCal), 0);
        checkOutput("midrun_rst_sat", 32'(oSat), 0);
        checkOutput("midrun_rst_busy", 32'(oBusy), 0);
        checkOutput("midrun_rst_done", 32'(oCal_done), 0);
        repeat (3) @(posedge iClk);
        @(negedge iClk) iRst_n = 1'b1;
        repeat (5) @(posedge iClk);
        #1;
        checkOutput("midrun_no_done", done_total, done_before);
        checkOutput("midrun_no_restart", 32'(oBusy), 0);
        @(negedge iClk) iCal_en = 1'b0;
        runCalc(0);
        checkOutput("post_rst_ch0", cal(0), 100);
        checkOutput("post_rst_ch1", cal(1), 10);
        checkOutput("done_per_run", done_total, runs);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
